// File: rtl/balance_cntrl_mc.sv
// balance_cntrl_mc: balance controller with soft start, PID-style datapath,
// steering mix and overspeed fault detection.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   ptch       signed pitch sample
//   ptch_rt    signed pitch rate sample
//   vld        sample strobe; datapath runs only on strobed cycles in SOFT/RUN
//   pwr_up     enable; low forces OFF
//   rider_off  clears the integrator
//   steer_pot  unsigned steering potentiometer reading
//   en_steer   enables the steering term
//   lft_spd    registered left wheel speed (signed 12 bit)
//   rght_spd   registered right wheel speed (signed 12 bit)
//   too_fast   registered overspeed flag for the latest sample
//   fault      high while in FAULT
//   out_vld    one-cycle pulse when the speed outputs take a new sample
module balance_cntrl_mc #(
    parameter int unsigned FAST_SIM = 1,
    parameter int unsigned P_COEF   = 9,
    parameter int unsigned SS_W     = 9,
    parameter int          FAST_THR = 1536,
    parameter int unsigned TF_LIM   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] ptch,
    input  logic signed [15:0] ptch_rt,
    input  logic               vld,
    input  logic               pwr_up,
    input  logic               rider_off,
    input  logic        [11:0] steer_pot,
    input  logic               en_steer,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               too_fast,
    output logic               fault,
    output logic               out_vld
);

    localparam int unsigned      I_SHIFT = (FAST_SIM != 0) ? 2 : 6;
    localparam int unsigned      SS_STEP = (FAST_SIM != 0) ? 64 : 1;
    localparam int unsigned      CNT_W   = $clog2(TF_LIM + 1);
    localparam logic [SS_W-1:0]  SS_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TF_LIM);
    localparam logic signed [31:0] P_GAIN = 32'(P_COEF);

    typedef enum logic [1:0] {StOff, StSoft, StRun, StFault} state_e;

    function automatic logic signed [11:0] sat12(input logic signed [31:0] x);
        if (x > 32'sd2047) begin
            return 12'sd2047;
        end else if (x < -32'sd2048) begin
            return -12'sd2048;
        end
        return 12'(x);
    endfunction

    function automatic logic over_thr(input logic signed [11:0] v);
        logic signed [31:0] w;
        w = 32'(v);
        return (w > FAST_THR) || (-w > FAST_THR);
    endfunction

    state_e                  state, state_nxt;
    logic [SS_W-1:0]         ss_tmr, ss_nxt;
    logic [31:0]             ss_sum;
    logic signed [17:0]      integ;
    logic signed [18:0]      integ_sum;
    logic                    integ_ovf;
    logic [CNT_W-1:0]        tf_cnt;
    logic signed [9:0]       ptch_sat;
    logic signed [31:0]      sum_full, prod, scaled, steer;
    logic [11:0]             pot_c;
    logic signed [11:0]      sum_sat, lft_nxt, rght_nxt;
    logic                    too_fast_nxt, work, keep;

    // Datapath, evaluated with the current state's rules.
    always_comb begin
        if (ptch > 16'sd511) begin
            ptch_sat = 10'sd511;
        end else if (ptch < -16'sd512) begin
            ptch_sat = -10'sd512;
        end else begin
            ptch_sat = ptch[9:0];
        end

        // Integrator term uses the pre-update value.
        sum_full = 32'(ptch_sat) * P_GAIN + 32'(integ >>> I_SHIFT) - 32'(ptch_rt >>> 6);
        sum_sat  = sat12(sum_full);

        prod   = 32'(sum_sat) * signed'(32'(ss_tmr));
        scaled = (state == StSoft) ? (prod >>> SS_W) : 32'(sum_sat);

        if (steer_pot < 12'h200) begin
            pot_c = 12'h200;
        end else if (steer_pot > 12'hE00) begin
            pot_c = 12'hE00;
        end else begin
            pot_c = steer_pot;
        end
        steer = en_steer ? (((signed'(32'(pot_c)) - 32'sd2048) * 32'sd3) >>> 4) : 32'sd0;

        lft_nxt      = sat12(scaled + steer);
        rght_nxt     = sat12(scaled - steer);
        too_fast_nxt = over_thr(lft_nxt) || over_thr(rght_nxt);

        // Overflowing updates are dropped rather than wrapped.
        integ_sum = 19'(integ) + 19'(ptch_sat);
        integ_ovf = integ_sum[18] != integ_sum[17];

        ss_sum = 32'(ss_tmr) + SS_STEP;
        ss_nxt = (ss_sum >= 32'(SS_MAX)) ? SS_MAX : ss_sum[SS_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        if (!pwr_up) begin
            state_nxt = StOff;
        end else begin
            case (state)
                StOff:   state_nxt = StSoft;
                StSoft:  begin
                    if (tf_cnt >= CNT_LIM)     state_nxt = StFault;
                    else if (ss_nxt == SS_MAX) state_nxt = StRun;
                end
                StRun:   if (tf_cnt >= CNT_LIM) state_nxt = StFault;
                default: state_nxt = StFault;
            endcase
        end
        work = vld && ((state == StSoft) || (state == StRun));
        // Leaving the active states zeroes the outputs instead of publishing a sample.
        keep = (state_nxt == StSoft) || (state_nxt == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StOff;
            ss_tmr   <= '0;
            integ    <= '0;
            tf_cnt   <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            too_fast <= 1'b0;
            fault    <= 1'b0;
            out_vld  <= 1'b0;
        end else begin
            state   <= state_nxt;
            fault   <= (state_nxt == StFault);
            out_vld <= work && keep;

            if (state_nxt == StOff) begin
                ss_tmr <= '0;
            end else if (state == StSoft) begin
                ss_tmr <= ss_nxt;
            end

            if (state_nxt == StOff || rider_off) begin
                integ <= '0;
            end else if (work && !integ_ovf) begin
                integ <= integ_sum[17:0];
            end

            if (state_nxt == StOff) begin
                tf_cnt <= '0;
            end else if (work) begin
                if (!too_fast_nxt)        tf_cnt <= '0;
                else if (tf_cnt < CNT_LIM) tf_cnt <= tf_cnt + 1'b1;
            end

            if (!keep) begin
                lft_spd  <= '0;
                rght_spd <= '0;
                too_fast <= 1'b0;
            end else if (work) begin
                lft_spd  <= lft_nxt;
                rght_spd <= rght_nxt;
                too_fast <= too_fast_nxt;
            end
        end
    end

endmodule

// File: tb/tb_balance_cntrl_mc.sv
// tb_balance_cntrl_mc: randomized + directed bench for balance_cntrl_mc with a
// behavioural reference model and an out_vld-driven scoreboard.
module tb_balance_cntrl_mc;

    localparam int M_OFF  = 0;
    localparam int M_SOFT = 1;
    localparam int M_RUN  = 2;
    localparam int M_FLT  = 3;
    localparam int TF_LIM = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] ptch, ptch_rt;
    logic               vld, pwr_up, rider_off, en_steer;
    logic        [11:0] steer_pot;
    logic signed [11:0] lft_spd, rght_spd;
    logic               too_fast, fault, out_vld;

    always #5 clk = ~clk;

    balance_cntrl_mc dut (
        .clk       (clk),
        .rst       (rst),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .vld       (vld),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .steer_pot (steer_pot),
        .en_steer  (en_steer),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .too_fast  (too_fast),
        .fault     (fault),
        .out_vld   (out_vld)
    );

    typedef struct {
        int l;
        int r;
        int tf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_st, m_ss, m_integ, m_cnt, m_l, m_r, m_tf, m_fault, m_ovld;

    function automatic int clampi(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_OFF; m_ss = 0; m_integ = 0; m_cnt = 0;
        m_l = 0; m_r = 0; m_tf = 0; m_fault = 0; m_ovld = 0;
    endtask

    // One clock of the reference model, using the inputs about to be sampled.
    task automatic model_step();
        int ps, s, sc, pc, stv, l, r, tf, nxt, t;
        bit work, keep;
        work = vld && (m_st == M_SOFT || m_st == M_RUN);
        if (!pwr_up)                                 nxt = M_OFF;
        else if (m_st == M_OFF)                      nxt = M_SOFT;
        else if (m_st == M_FLT)                      nxt = M_FLT;
        else if (m_cnt >= TF_LIM)                    nxt = M_FLT;
        else if (m_st == M_SOFT && m_ss + 64 >= 511) nxt = M_RUN;
        else                                         nxt = m_st;

        ps  = clampi(int'(ptch), -512, 511);
        s   = clampi(ps * 9 + (m_integ >>> 2) - (int'(ptch_rt) >>> 6), -2048, 2047);
        sc  = (m_st == M_SOFT) ? ((s * m_ss) >>> 9) : s;
        pc  = clampi(int'(steer_pot), 512, 3584);
        stv = en_steer ? (((pc - 2048) * 3) >>> 4) : 0;
        l   = clampi(sc + stv, -2048, 2047);
        r   = clampi(sc - stv, -2048, 2047);
        tf  = (l > 1536 || l < -1536 || r > 1536 || r < -1536) ? 1 : 0;

        keep   = (nxt == M_SOFT || nxt == M_RUN);
        m_ovld = (work && keep) ? 1 : 0;
        if (!keep) begin
            m_l = 0; m_r = 0; m_tf = 0;
        end else if (work) begin
            m_l = l; m_r = r; m_tf = tf;
            exp_q.push_back('{l, r, tf});
        end

        if (nxt == M_OFF || rider_off) begin
            m_integ = 0;
        end else if (work) begin
            t = m_integ + ps;
            if (t >= -131072 && t <= 131071) m_integ = t;
        end

        if (nxt == M_OFF)  m_cnt = 0;
        else if (work)     m_cnt = tf ? ((m_cnt < TF_LIM) ? m_cnt + 1 : TF_LIM) : 0;

        if (nxt == M_OFF)        m_ss = 0;
        else if (m_st == M_SOFT) m_ss = (m_ss + 64 > 511) ? 511 : m_ss + 64;

        m_st    = nxt;
        m_fault = (m_st == M_FLT) ? 1 : 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("fault", int'(fault), m_fault);
        check("out_vld", int'(out_vld), m_ovld);
        check("lft_spd", int'(lft_spd), m_l);
        check("rght_spd", int'(rght_spd), m_r);
        check("too_fast", int'(too_fast), m_tf);
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_too_fast", int'(too_fast), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_out_vld", int'(out_vld), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: out_vld=1 with no expected sample (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_lft", int'(lft_spd), e.l);
                check("sb_rght", int'(rght_spd), e.r);
                check("sb_too_fast", int'(too_fast), e.tf);
            end
        end
    end

    initial begin
        rst = 1'b1; pwr_up = 1'b1; vld = 1'b0; rider_off = 1'b0;
        ptch = '0; ptch_rt = '0; en_steer = 1'b0; steer_pot = 12'h800;
        model_reset();
        #1;
        check("por_lft", int'(lft_spd), 0);
        check("por_fault", int'(fault), 0);
        check("por_out_vld", int'(out_vld), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Soft start: sample at ss_tmr=256 gives half of 900.
        repeat (5) tick();
        ptch = 16'sd100; vld = 1'b1;
        tick();
        check("soft_half", int'(lft_spd), 450);
        vld = 1'b0;
        repeat (3) tick();

        // Now in RUN: integ=100 contributes 25 unscaled; rider_off clears it.
        ptch = 16'sd0; rider_off = 1'b1; vld = 1'b1;
        tick();
        check("run_entry_i", int'(lft_spd), 25);
        rider_off = 1'b0; ptch = 16'sd100;
        tick();
        check("p_900", int'(lft_spd), 900);
        tick();
        check("pi_925", int'(rght_spd), 925);
        ptch = 16'sd0; rider_off = 1'b1;
        tick();
        rider_off = 1'b0; ptch_rt = 16'sd640;
        tick();
        check("d_lft", int'(lft_spd), -10);
        check("d_rght", int'(rght_spd), -10);

        ptch_rt = 16'sd0; en_steer = 1'b1; steer_pot = 12'hFFF;
        tick();
        check("steer_r_lft", int'(lft_spd), 288);
        check("steer_r_rght", int'(rght_spd), -288);
        steer_pot = 12'h000;
        tick();
        check("steer_l_lft", int'(lft_spd), -288);
        check("steer_l_rght", int'(rght_spd), 288);

        // Overspeed: four saturated samples, then FAULT.
        en_steer = 1'b0; steer_pot = 12'h800; ptch = 16'sd2000;
        repeat (TF_LIM) begin
            tick();
            check("ovs_out", int'(lft_spd), 2047);
            check("ovs_flag", int'(too_fast), 1);
        end
        vld = 1'b0;
        tick();
        check("fault_set", int'(fault), 1);
        check("fault_zero", int'(lft_spd), 0);
        vld = 1'b1;
        tick();
        check("fault_sticky", int'(fault), 1);
        pwr_up = 1'b0; vld = 1'b0;
        tick();
        check("fault_clear", int'(fault), 0);

        // Reset mid-operation.
        pwr_up = 1'b1; vld = 1'b1; ptch = 16'sd50;
        repeat (12) tick();
        do_reset();

        // Dropping pwr_up mid-ramp restarts the soft start from zero.
        vld = 1'b0; ptch = 16'sd100;
        repeat (3) tick();
        pwr_up = 1'b0;
        tick();
        pwr_up = 1'b1;
        repeat (5) tick();
        vld = 1'b1;
        tick();
        check("restart_half", int'(lft_spd), 450);

        for (int i = 0; i < 3000; i++) begin
            pwr_up    = ($urandom_range(0, 99) != 0);
            vld       = 1'($urandom_range(0, 1));
            rider_off = ($urandom_range(0, 31) == 0);
            en_steer  = 1'($urandom_range(0, 1));
            steer_pot = 12'($urandom);
            ptch_rt   = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       ptch = 16'($urandom);
                1:       ptch = 16'($urandom_range(0, 400));
                2:       ptch = 16'(0 - int'($urandom_range(0, 400)));
                default: ptch = 16'sd0;
            endcase
            tick();
        end

        vld = 1'b0;
        repeat (2) tick();
        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/balance_cntrl_mc.md
BALANCE_CNTRL_MC -- requirements
Module: balance_cntrl_mc

Interface
REQ-001 The block SHALL have parameter FAST_SIM, default 1, meaning 1 selects I_SHIFT=2 and SS_STEP=64, while 0 selects I_SHIFT=6 and SS_STEP=1.
REQ-002 The block SHALL have parameter P_COEF, default 9, meaning the unsigned proportional gain.
REQ-003 The block SHALL have parameter SS_W, default 9, meaning the soft-start timer width.
REQ-004 The block SHALL have parameter FAST_THR, default 1536, meaning the overspeed magnitude threshold.
REQ-005 The block SHALL have parameter TF_LIM, default 4, meaning the number of consecutive overspeed samples that causes fault.
REQ-006 The block SHALL have port clk, input, 1 bit: the system clock; all state SHALL be on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port ptch, input, 16 bits signed: pitch.
REQ-009 The block SHALL have port ptch_rt, input, 16 bits signed: pitch rate.
REQ-010 The block SHALL have port vld, input, 1 bit: sample strobe.
REQ-011 The block SHALL have port pwr_up, input, 1 bit: enable.
REQ-012 The block SHALL have port rider_off, input, 1 bit: clears the integrator.
REQ-013 The block SHALL have port steer_pot, input, 12 bits unsigned.
REQ-014 The block SHALL have port en_steer, input, 1 bit.
REQ-015 The block SHALL have ports lft_spd and rght_spd, output, 12 bits signed each, registered.
REQ-016 The block SHALL have port too_fast, output, 1 bit, registered.
REQ-017 The block SHALL have port fault, output, 1 bit: high while in state FAULT.
REQ-018 The block SHALL have port out_vld, output, 1 bit: one-cycle pulse when the speed outputs update.

Function
REQ-019 The state machine SHALL have states OFF, SOFT, RUN and FAULT.
REQ-020 From any state, pwr_up=0 SHALL cause a transition to OFF on the next edge.
REQ-021 In OFF, pwr_up=1 SHALL cause a transition to SOFT.
REQ-022 In SOFT, ss_tmr SHALL add SS_STEP every cycle, saturating at 2^SS_W-1.
REQ-023 In SOFT, the block SHALL transition to RUN on the cycle ss_tmr reaches its maximum.
REQ-024 In SOFT or RUN, reaching the overspeed sample limit (REQ-036) SHALL cause a transition to FAULT.
REQ-025 In OFF, ss_tmr, the integrator and the overspeed counter SHALL be held at 0.
REQ-026 In OFF and FAULT, lft_spd=rght_spd=0.
REQ-027 FAULT SHALL exit only through pwr_up=0.
REQ-028 Datapath work SHALL occur only on cycles with vld=1 in SOFT or RUN.
REQ-029 The speed outputs SHALL update on the edge that samples vld, and out_vld SHALL pulse in the same cycle, giving a latency of 1 clock.
REQ-030 The datapath SHALL compute:
- ptch_sat = ptch saturated to signed 10 bits [-512,511];
- P = ptch_sat*P_COEF;
- I = integ >>> I_SHIFT, where integ is the pre-update value;
- D = -(ptch_rt >>> 6);
- sum = P+I+D, computed at full width then saturated to signed 12 bits [-2048,2047].
REQ-031 The integrator SHALL be 18-bit signed, and integ += sext(ptch_sat) when vld=1.
REQ-032 An integrator update that would overflow 18 bits SHALL be discarded, leaving the integrator unchanged with no wrap.
REQ-033 rider_off=1 SHALL clear the integrator to 0 that cycle, with priority over vld.
REQ-034 The soft-start output SHALL be scaled = (sum*ss_tmr) >>> SS_W in SOFT; in RUN, scaled = sum unscaled.
REQ-035 Steering SHALL be computed as:
- pot_c = steer_pot clamped to [0x200,0xE00];
- st = ((pot_c-0x800)*3) >>> 4, signed;
- when en_steer=0, st = 0;
- lft_spd = sat12(scaled+st) and rght_spd = sat12(scaled-st).
REQ-036 On each vld in SOFT or RUN, too_fast SHALL be set to (|lft_spd|>FAST_THR or |rght_spd|>FAST_THR), evaluated on the new values.
REQ-037 The overspeed counter SHALL increment when too_fast is set and clear to 0 otherwise; reaching TF_LIM SHALL cause FAULT on the next edge.
REQ-038 When vld=1 and a state change occur in the same cycle, the datapath SHALL use the current-state rules.
REQ-039 Deassertion of pwr_up mid-ramp SHALL clear ss_tmr, so a later pwr_up restarts the soft start from 0.

Reset
REQ-040 rst=1 SHALL immediately force state OFF, with ss_tmr, integ, the overspeed counter, lft_spd, rght_spd, too_fast, fault and out_vld all 0, independent of clk.
REQ-041 Reset asserted mid-operation SHALL discard all state; after release the block SHALL behave as if from power-on.

Verification
REQ-042 Reset scenario: assert rst with pwr_up=1 -> all outputs 0 and state OFF; release, pwr_up=1, FAST_SIM=1 -> RUN reached after 8 cycles.
REQ-043 Proportional/integral scenario: in RUN with ptch=100, ptch_rt=0, integ=0, en_steer=0, vld pulse -> lft_spd=rght_spd=900 and out_vld=1; second vld -> 925.
REQ-044 Derivative/rider_off scenario: in RUN with ptch=0, ptch_rt=640 -> outputs -10; apply rider_off with vld -> integ=0.
REQ-045 Steering scenario: in RUN with ptch=0, integ=0, en_steer=1, steer_pot=0xFFF -> lft_spd=288 and rght_spd=-288; steer_pot=0x000 -> lft_spd=-288 and rght_spd=288.
REQ-046 Overspeed scenario: in RUN with ptch=2000 -> outputs 2047 and too_fast=1; after 4 consecutive vld -> fault=1 and outputs 0; pwr_up=0 -> OFF with fault=0.
REQ-047 Soft-start scenario: with FAST_SIM=1, SOFT, ss_tmr=256, sum=900 -> outputs 450; pwr_up dropped mid-ramp -> ss_tmr=0.
